pkt_frame_checker: RTL and testbench

- Stream stage directly downstream of the packet FIFO wrapper. It consumes the FIFO's valid/ready/sop/eop beat stream and guarantees well-formed framing to the consumer.
- Malformed input is repaired on the fly:
  - beats outside a packet are discarded;
  - a missing eop is closed with a synthetic filler beat;
  - over-length packets are truncated.
- Output is a single registered pipeline stage with full throughput. Optional packet and error statistics.

---
 rtl/pkt_frame_checker.sv | 174 +++++++++++++++++
 tb/tb_pkt_frame_checker.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pkt_frame_checker.sv
// pkt_frame_checker: repairs sop/eop framing of a valid/ready beat stream behind one output register.
// Statistics counters (pkt_cnt, err_cnt) exist only when PKT_FRAME_CHECKER_STATS_EN is defined.
module pkt_frame_checker #(
   parameter int DATA_WIDTH = 20,
   parameter int MAX_BEATS  = 1024,
   parameter int CNT_WIDTH  = 32
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DATA_WIDTH-1:0] in_data,
   input  logic                  in_sop,
   input  logic                  in_eop,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic                  out_sop,
   output logic                  out_eop,
   output logic [CNT_WIDTH-1:0]  pkt_cnt,
   output logic [CNT_WIDTH-1:0]  err_cnt
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      IN_PKT = 2'd1,
      DROP   = 2'd2
   } state_t;

   // Beat index of the last beat a packet may carry before it is cut short.
   localparam logic [15:0] LAST_BEAT = 16'(MAX_BEATS - 1);

   state_t                state_q;
   state_t                state_d;
   logic [15:0]           beat_cnt_q;
   logic [15:0]           beat_cnt_d;

   logic                  load_ok;
   logic                  fwd;
   logic                  filler;
   logic                  trunc;

   logic                  load_p0;
   logic [DATA_WIDTH-1:0] data_p0;
   logic                  sop_p0;
   logic                  eop_p0;

   logic                  vld_p1;
   logic [DATA_WIDTH-1:0] data_p1;
   logic                  sop_p1;
   logic                  eop_p1;

   assign load_ok = !vld_p1 || out_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         beat_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         beat_cnt_q <= beat_cnt_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      beat_cnt_d = beat_cnt_q;
      fwd        = 1'b0;
      filler     = 1'b0;
      trunc      = 1'b0;
      in_ready   = load_ok;
      case (state_q)
         IN_PKT: begin
            if (in_valid && in_sop) begin
               // New sop while a packet is open: hold it and close the open packet first.
               in_ready = 1'b0;
               if (load_ok) begin
                  filler     = 1'b1;
                  state_d    = IDLE;
                  beat_cnt_d = '0;
               end
            end else if (in_valid && load_ok) begin
               fwd        = 1'b1;
               beat_cnt_d = beat_cnt_q + 16'd1;
               if (in_eop) begin
                  state_d    = IDLE;
                  beat_cnt_d = '0;
               end else if (beat_cnt_q == LAST_BEAT) begin
                  trunc      = 1'b1;
                  state_d    = DROP;
                  beat_cnt_d = '0;
               end
            end
         end
         default: begin
            // IDLE and DROP share sop handling; only orphan accounting differs.
            if (in_sop) begin
               if (in_valid && load_ok) begin
                  fwd = 1'b1;
                  if (in_eop) begin
                     state_d    = IDLE;
                     beat_cnt_d = '0;
                  end else begin
                     state_d    = IN_PKT;
                     beat_cnt_d = 16'd1;
                  end
               end
            end else begin
               in_ready = 1'b1;
               if (in_valid && in_eop && state_q == DROP) begin
                  state_d = IDLE;
               end
            end
         end
      endcase
   end

   assign load_p0 = fwd || filler;
   assign data_p0 = filler ? '0 : in_data;
   assign sop_p0  = !filler && in_sop;
   assign eop_p0  = filler || in_eop || trunc;

   // ---- p0 -> p1 : output register ----
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_p1  <= 1'b0;
         data_p1 <= '0;
         sop_p1  <= 1'b0;
         eop_p1  <= 1'b0;
      end else if (load_p0) begin
         vld_p1  <= 1'b1;
         data_p1 <= data_p0;
         sop_p1  <= sop_p0;
         eop_p1  <= eop_p0;
      end else if (out_ready) begin
         vld_p1  <= 1'b0;
      end
   end

   assign out_valid = vld_p1;
   assign out_data  = data_p1;
   assign out_sop   = sop_p1;
   assign out_eop   = eop_p1;

`ifdef PKT_FRAME_CHECKER_STATS_EN
   function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

   logic [CNT_WIDTH-1:0] pkt_cnt_q;
   logic [CNT_WIDTH-1:0] err_cnt_q;
   logic                 err_inc;

   // Orphans count only in IDLE; beats dropped after truncation were already charged.
   assign err_inc = (state_q == IDLE && in_valid && !in_sop) || filler || trunc;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pkt_cnt_q <= '0;
         err_cnt_q <= '0;
      end else begin
         if (load_p0 && eop_p0) pkt_cnt_q <= sat_inc(pkt_cnt_q);
         if (err_inc)           err_cnt_q <= sat_inc(err_cnt_q);
      end
   end

   assign pkt_cnt = pkt_cnt_q;
   assign err_cnt = err_cnt_q;
`else
   assign pkt_cnt = '0;
   assign err_cnt = '0;
`endif

endmodule

// File: tb/tb_pkt_frame_checker.sv
// Directed bench for pkt_frame_checker with MAX_BEATS=4: framing repair, backpressure and async reset.
module tb_pkt_frame_checker;

   localparam int DW = 20;
   localparam int CW = 32;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [DW-1:0] in_data = '0;
   logic          in_sop = 1'b0;
   logic          in_eop = 1'b0;
   logic          out_valid;
   logic          out_ready = 1'b1;
   logic [DW-1:0] out_data;
   logic          out_sop;
   logic          out_eop;
   logic [CW-1:0] pkt_cnt;
   logic [CW-1:0] err_cnt;

   int checks = 0;
   int errors = 0;
   int stalls = 0;

   logic [DW+1:0] exp_q[$];
   logic [DW+1:0] cap_q[$];
   logic          hold_prev = 1'b0;
   logic [DW+1:0] prev_beat = '0;

   pkt_frame_checker #(.DATA_WIDTH(DW), .MAX_BEATS(4), .CNT_WIDTH(CW)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .in_sop(in_sop), .in_eop(in_eop),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_sop(out_sop), .out_eop(out_eop),
      .pkt_cnt(pkt_cnt), .err_cnt(err_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Counters read zero when the statistics option is not built.
   function automatic logic [63:0] sx(input int v);
`ifdef PKT_FRAME_CHECKER_STATS_EN
      return 64'(v);
`else
      return (v == -1) ? 64'd1 : 64'd0;
`endif
   endfunction

   // Monitor: record accepted output beats and check that a stalled beat holds steady.
   always @(negedge clk) begin
      if (!rst_n) begin
         hold_prev = 1'b0;
      end else begin
         if (hold_prev) check("hold_stable", {out_sop, out_eop, out_data}, prev_beat);
         if (out_valid && out_ready) cap_q.push_back({out_sop, out_eop, out_data});
         hold_prev = out_valid && !out_ready;
         prev_beat = {out_sop, out_eop, out_data};
      end
   end

   task automatic send(input logic [DW-1:0] d, input logic s, input logic e);
      bit acc = 1'b0;
      int n = 0;
      in_valid = 1'b1;
      in_data  = d;
      in_sop   = s;
      in_eop   = e;
      while (!acc && n < 50) begin
         @(negedge clk);
         if (in_ready) acc = 1'b1;
         else begin
            stalls++;
            n++;
         end
      end
      check($sformatf("accept_%0h", d), 64'(acc), 64'd1);
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      in_valid = 1'b0;
      in_sop   = 1'b0;
      in_eop   = 1'b0;
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      in_valid  = 1'b0;
      out_ready = 1'b1;
      rst_n     = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n  = 1'b1;
      stalls = 0;
      exp_q.delete();
      cap_q.delete();
      @(posedge clk);
      #1;
   endtask

   task automatic expect_beat(input logic [DW-1:0] d, input logic s, input logic e);
      exp_q.push_back({s, e, d});
   endtask

   task automatic compare_stream(input string tag);
      int n;
      check({tag, "_nbeats"}, 64'(cap_q.size()), 64'(exp_q.size()));
      n = (cap_q.size() < exp_q.size()) ? cap_q.size() : exp_q.size();
      for (int i = 0; i < n; i++)
         check($sformatf("%s_beat%0d", tag, i), 64'(cap_q[i]), 64'(exp_q[i]));
      exp_q.delete();
      cap_q.delete();
   endtask

   task automatic ready_pattern();
      logic [3:0] pat = 4'b1001;
      for (int i = 3; i >= 0; i--) begin
         out_ready = pat[i];
         @(posedge clk);
         #1;
      end
      out_ready = 1'b1;
   endtask

   task automatic send_g();
      send(20'h00071, 1'b1, 1'b0);
      send(20'h00072, 1'b0, 1'b0);
      send(20'h00073, 1'b0, 1'b1);
      idle(1);
   endtask

   initial begin
      do_reset();
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_out_data", 64'(out_data), 64'd0);
      check("rst_pkt_cnt", 64'(pkt_cnt), 64'd0);
      check("rst_err_cnt", 64'(err_cnt), 64'd0);
      check("rst_in_ready", 64'(in_ready), 64'd1);

      // Clean 3-beat packet, one cycle latency, no stalls.
      send(20'hA0001, 1'b1, 1'b0);
      check("t1_latency_valid", 64'(out_valid), 64'd1);
      check("t1_latency_data", 64'(out_data), 64'hA0001);
      send(20'hA0002, 1'b0, 1'b0);
      send(20'hA0003, 1'b0, 1'b1);
      idle(3);
      expect_beat(20'hA0001, 1'b1, 1'b0);
      expect_beat(20'hA0002, 1'b0, 1'b0);
      expect_beat(20'hA0003, 1'b0, 1'b1);
      compare_stream("t1");
      check("t1_stalls", 64'(stalls), 64'd0);
      check("t1_pkt_cnt", 64'(pkt_cnt), sx(1));
      check("t1_err_cnt", 64'(err_cnt), sx(0));

      // Orphans before a single-beat packet.
      do_reset();
      send(20'h00011, 1'b0, 1'b0);
      send(20'h00022, 1'b0, 1'b0);
      send(20'h00033, 1'b1, 1'b1);
      idle(3);
      expect_beat(20'h00033, 1'b1, 1'b1);
      compare_stream("t2");
      check("t2_err_cnt", 64'(err_cnt), sx(2));
      check("t2_pkt_cnt", 64'(pkt_cnt), sx(1));

      // Missing eop closed by a filler beat; the new sop stalls one cycle.
      do_reset();
      send(20'hB0001, 1'b1, 1'b0);
      send(20'hB0002, 1'b0, 1'b0);
      send(20'hC0001, 1'b1, 1'b1);
      idle(3);
      expect_beat(20'hB0001, 1'b1, 1'b0);
      expect_beat(20'hB0002, 1'b0, 1'b0);
      expect_beat(20'h00000, 1'b0, 1'b1);
      expect_beat(20'hC0001, 1'b1, 1'b1);
      compare_stream("t3");
      check("t3_stalls", 64'(stalls), 64'd1);
      check("t3_err_cnt", 64'(err_cnt), sx(1));
      check("t3_pkt_cnt", 64'(pkt_cnt), sx(2));

      // Over-length packet truncated at beat 4, rest dropped silently.
      do_reset();
      for (int i = 1; i <= 6; i++)
         send(20'hD0000 + 20'(i), i == 1, i == 6);
      idle(3);
      check("t4_err_cnt", 64'(err_cnt), sx(1));
      check("t4_pkt_cnt", 64'(pkt_cnt), sx(1));
      send(20'hE0001, 1'b1, 1'b1);
      idle(3);
      expect_beat(20'hD0001, 1'b1, 1'b0);
      expect_beat(20'hD0002, 1'b0, 1'b0);
      expect_beat(20'hD0003, 1'b0, 1'b0);
      expect_beat(20'hD0004, 1'b0, 1'b1);
      expect_beat(20'hE0001, 1'b1, 1'b1);
      compare_stream("t4");
      check("t4_pkt_cnt_e", 64'(pkt_cnt), sx(2));
      check("t4_err_cnt_e", 64'(err_cnt), sx(1));

      // Packet of exactly the limit with eop on the last beat is legal.
      do_reset();
      for (int i = 1; i <= 4; i++)
         send(20'hF0000 + 20'(i), i == 1, i == 4);
      idle(3);
      for (int i = 1; i <= 4; i++)
         expect_beat(20'hF0000 + 20'(i), i == 1, i == 4);
      compare_stream("t5");
      check("t5_err_cnt", 64'(err_cnt), sx(0));
      check("t5_pkt_cnt", 64'(pkt_cnt), sx(1));

      // Backpressure: out_ready 1,0,0,1 while a 3-beat packet flows.
      do_reset();
      fork
         ready_pattern();
         send_g();
      join
      idle(3);
      expect_beat(20'h00071, 1'b1, 1'b0);
      expect_beat(20'h00072, 1'b0, 1'b0);
      expect_beat(20'h00073, 1'b0, 1'b1);
      compare_stream("t6");
      check("t6_stalls", 64'(stalls), 64'd2);
      check("t6_pkt_cnt", 64'(pkt_cnt), sx(1));

      // Asynchronous reset mid-packet.
      do_reset();
      send(20'h00044, 1'b0, 1'b0);
      send(20'h00081, 1'b1, 1'b0);
      send(20'h00082, 1'b0, 1'b0);
      in_valid = 1'b0;
      check("t7_pre_valid", 64'(out_valid), 64'd1);
      check("t7_pre_err_cnt", 64'(err_cnt), sx(1));
      #2;
      rst_n = 1'b0;
      #1;
      check("t7_rst_valid", 64'(out_valid), 64'd0);
      check("t7_rst_data", 64'(out_data), 64'd0);
      check("t7_rst_sopeop", 64'({out_sop, out_eop}), 64'd0);
      check("t7_rst_err_cnt", 64'(err_cnt), 64'd0);
      check("t7_rst_pkt_cnt", 64'(pkt_cnt), 64'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      cap_q.delete();
      @(posedge clk);
      #1;
      send(20'h00055, 1'b0, 1'b0);
      idle(3);
      compare_stream("t7");
      check("t7_err_cnt", 64'(err_cnt), sx(1));
      check("t7_out_valid", 64'(out_valid), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

endmodule
